// File: rtl/piso_bit_feeder.sv
// rtl/piso_bit_feeder.sv - parallel-in/serial-out bit feeder for the sequence detectors
// Optional even-parity bit per word when PISO_PARITY_EN is defined.
module piso_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy,
  output logic [15:0]      words_sent
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             at_last;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A completing word and a newly accepted word share one edge, so SHIFT never drops to IDLE then.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (at_last && !din_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SHIFT);
    at_last   = (state == SHIFT) && (cnt == '0);
    last_bit  = at_last;
    din_ready = (state == IDLE) || at_last;
    accept    = din_valid && din_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (accept) begin
      shreg   <= din;
      cnt     <= CW'(NBITS - 1);
      x       <= MSB_FIRST ? din[WIDTH-1] : din[0];
      x_valid <= 1'b1;
`ifdef PISO_PARITY_EN
      par     <= ^din;
`endif
    end else if (state == SHIFT) begin
      if (cnt == '0) begin
        x       <= IDLE_BIT;
        x_valid <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
`ifdef PISO_PARITY_EN
        if (cnt == CW'(1)) begin
          x <= par;
        end else begin
          x     <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
          shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        end
`else
        x     <= MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent <= '0;
    end else if (at_last) begin
      words_sent <= words_sent + 16'd1;
    end
  end

endmodule

// File: doc/piso_bit_feeder.md
Name: piso_bit_feeder

Overview:
- Parallel-in/serial-out stage directly upstream of the Moore sequence detectors (e.g. the 11011 detector).
- Accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clk on x, which wires straight to the detector's x input.
- Supports back-to-back words with no idle gap, so overlapping patterns that span a word boundary reach the detector intact.
- Also provides a status flag and a sent-word counter for benches and higher-level control.

Parameters:
- WIDTH, 8, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
- IDLE_BIT, 0, value driven on x while no word is in flight.

Ports:
- clk  input  1  rising-edge clock, shared with the downstream detector.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block accepts din on this edge.
- x  output  1  serial bit to the detector; registered.
- x_valid  output  1  x carries a data bit (or parity bit); registered.
- last_bit  output  1  current x is the final bit of its word.
- busy  output  1  state is SHIFT.
- words_sent  output  16  count of completed words; wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- State machine: two states, IDLE and SHIFT.
  - Internal registers: shreg[WIDTH-1:0] and cnt (bits remaining after the current one).
- Reset values, applied immediately on rst_n=0 and independent of clk:
  - state=IDLE, x=IDLE_BIT, x_valid=0, cnt=0, shreg=0, words_sent=0.
  - Reset mid-word abandons the word. words_sent is not incremented for it.
- Combinational outputs:
  - din_ready = (state==IDLE) || (state==SHIFT && cnt==0).
  - last_bit = (state==SHIFT && cnt==0).
  - busy = (state==SHIFT).
- Accept: occurs on a rising edge where din_valid && din_ready.
  - shreg <= din.
  - x <= first bit (per MSB_FIRST).
  - x_valid <= 1, cnt <= WIDTH-1, state <= SHIFT.
  - Latency: the first bit appears on x in the cycle after the accepting edge.
- SHIFT with cnt!=0: each edge presents the next bit on x and decrements cnt.
  - Bit order follows MSB_FIRST. The word occupies exactly WIDTH consecutive cycles on x.
- SHIFT with cnt==0 (last bit on x). At the edge:
  - words_sent <= words_sent+1, wrapping 16'hFFFF to 0.
  - If din_valid=1: accept the new word as above. x_valid stays 1 with no gap cycle.
  - If din_valid=0: state <= IDLE, x <= IDLE_BIT, x_valid <= 0.
- din_valid while din_ready=0 is ignored, not queued.
  - The upstream holds din/din_valid until it sees ready.
  - din may change freely when not accepted.
- In IDLE, x holds IDLE_BIT every cycle. The detector sees a steady IDLE_BIT stream.
- A word completing and a new word loading are the same edge. The count increments once and the load proceeds.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - After the WIDTH data bits, one even-parity bit (XOR of the word) is sent, so each word spans WIDTH+1 cycles.
  - cnt loads WIDTH on accept.
  - last_bit and din_ready assert during the parity bit.
  - words_sent increments at the end of the parity bit.
- When undefined: no parity bit. Behaviour is exactly as above.

Test Plan:
- Reset check: hold rst_n=0 mid-clock-low, then release. Required: x=0, x_valid=0, din_ready=1, busy=0, words_sent=0 asynchronously. Release during a word (after 3 bits) returns to IDLE with words_sent unchanged.
- Single word, WIDTH=8, MSB_FIRST=1: accept din=8'b0001_1011 with one-cycle valid. Required: x = 0,0,0,1,1,0,1,1 on 8 consecutive cycles with x_valid=1. last_bit is high on the 8th bit only. Then x=0, x_valid=0, words_sent=1.
- Back-to-back: din=8'h1B then 8'hDB with valid held. Required: 16 contiguous x_valid cycles. Bits are 00011011 11011011, with no gap at the boundary. din_ready pulses only on the two last_bit cycles. words_sent=2.
- Gap and stall: assert din_valid with a changing din while busy and cnt!=0. Required: the in-flight word is unaffected, and only the din present at the last_bit edge is loaded.
- LSB-first and wrap: MSB_FIRST=0, din=8'h1B. Required: x = 1,1,0,1,1,0,0,0. Preload 65535 completions, send one more word; required: words_sent=0.
- With PISO_PARITY_EN: din=8'h1B (four ones). Required: 9 bits, last bit 0. din=8'h1A: last bit 1. last_bit is high on the 9th cycle.
